// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared widths, terminal count and lap entry layout for the stopwatch lap buffer
package stopwatch_pkg;
  localparam int SW_DATA_WIDTH = 16;
  localparam int SW_MAX = 99;
  typedef struct packed {
    logic [SW_DATA_WIDTH-1:0] total;
    logic [SW_DATA_WIDTH-1:0] delta;
  } lap_entry_t;
endpackage

// File: rtl/stopwatch_lap_buffer_if.sv
// stopwatch_lap_buffer_if: lap request inputs and show-ahead lap stream towards the display stage
interface stopwatch_lap_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 4
);
  logic [DATA_WIDTH-1:0] count;
  logic lap;
  logic clear;
  logic out_ready;
  logic out_valid;
  logic [DATA_WIDTH-1:0] lap_total;
  logic [DATA_WIDTH-1:0] lap_delta;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  logic overflow;
  modport master (
    output count, lap, clear, out_ready,
    input out_valid, lap_total, lap_delta, occupancy, overflow
  );
  modport slave (
    input count, lap, clear, out_ready,
    output out_valid, lap_total, lap_delta, occupancy, overflow
  );
endinterface

// File: rtl/lap_fifo.sv
// lap_fifo: show-ahead synchronous FIFO allowing push and pop together even when full
module lap_fifo #(
  parameter type T = logic [7:0],
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  T mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  // storage needs no reset: the head is masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (resetn && !clear && push) mem[wp] <= wdata;
  end
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign count = cnt;
  assign rdata = empty ? T'('0) : mem[rp];
endmodule

// File: rtl/stopwatch_lap_buffer.sv
// stopwatch_lap_buffer: captures lap totals and wrap-aware lap deltas into a small stream FIFO
module stopwatch_lap_buffer
  import stopwatch_pkg::*;
#(
  parameter int DATA_WIDTH = SW_DATA_WIDTH,
  parameter int MAX = SW_MAX,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic resetn,
  stopwatch_lap_buffer_if.slave bus
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] total;
    logic [DATA_WIDTH-1:0] delta;
  } entry_t;
  entry_t wr_entry, rd_entry;
  logic full, empty, push, pop, overflow;
  logic [DATA_WIDTH-1:0] prev_ref;
  logic [$clog2(DEPTH+1)-1:0] occ;
  // the wrap path result is at most MAX, so modular DATA_WIDTH arithmetic is exact
  always_comb begin
    pop = !empty && bus.out_ready;
    push = bus.lap && !bus.clear && (!full || pop);
    wr_entry.total = bus.count;
    wr_entry.delta = (bus.count >= prev_ref) ? bus.count - prev_ref
                   : bus.count + DATA_WIDTH'(MAX + 1) - prev_ref;
  end
  always_ff @(posedge clk) begin
    if (!resetn || bus.clear) begin
      prev_ref <= '0;
      overflow <= 1'b0;
    end else begin
      if (bus.lap) prev_ref <= bus.count;
      if (bus.lap && full && !pop) overflow <= 1'b1;
    end
  end
  lap_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
    .clk, .resetn, .clear(bus.clear), .push, .pop,
    .wdata(wr_entry), .rdata(rd_entry), .full, .empty, .count(occ)
  );
  assign bus.out_valid = !empty;
  assign bus.lap_total = rd_entry.total;
  assign bus.lap_delta = rd_entry.delta;
  assign bus.occupancy = occ;
  assign bus.overflow = overflow;
endmodule
